// File: rtl/clock_pkg.sv
// Shared definitions for the alarm unit: FSM state encoding and default time moduli.
package clock_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZING = 2'd3
  } alarm_state_t;

  localparam int DEF_HR_MOD  = 24;
  localparam int DEF_MIN_MOD = 60;

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter; one step per cycle 'step' is high, wrapping both ways.
module mod_updown_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  input  logic         dn,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (step) begin
      if (dn) count <= (count == '0) ? TOP : count - W'(1);
      else    count <= (count == TOP) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm setting registers plus disarmed/armed/ringing/snoozing FSM.
// Define ALARM_SNOOZE_EN to enable the snooze input and SNOOZING state.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int HR_MOD         = DEF_HR_MOD,
  parameter int MIN_MOD        = DEF_MIN_MOD,
  parameter int HR_W           = 5,
  parameter int MIN_W          = 6,
  parameter int RING_MINUTES   = 1,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             set_hr,
  input  logic             set_min,
  input  logic             set_dn,
  input  logic             arm,
  input  logic             stop,
  input  logic             snooze,
  input  logic             min_tick,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  output logic [HR_W-1:0]  alarm_hr,
  output logic [MIN_W-1:0] alarm_min,
  output logic             ringing,
  output logic             snoozing,
  output logic             armed
);

  localparam int RW = $clog2(RING_MINUTES + 1);

  alarm_state_t   state, state_nxt;
  logic [RW-1:0]  ring_cnt, ring_nxt, ring_inc;
  logic           match;

  mod_updown_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
    .clock (clock),
    .reset (reset),
    .step  (enable & set_hr),
    .dn    (set_dn),
    .count (alarm_hr)
  );

  mod_updown_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clock (clock),
    .reset (reset),
    .step  (enable & set_min),
    .dn    (set_dn),
    .count (alarm_min)
  );

  // Compare uses the registers as they stand this cycle, before any setting step lands.
  assign match    = min_tick & (cur_hr == alarm_hr) & (cur_min == alarm_min);
  assign ring_inc = ring_cnt + RW'(1);

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MINUTES + 1);
  logic [SW-1:0] snz_cnt, snz_nxt;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= DISARMED;
      ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_nxt;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= snz_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    ring_nxt  = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_nxt   = snz_cnt;
`endif
    if (!arm) begin
      state_nxt = DISARMED;
      ring_nxt  = '0;
`ifdef ALARM_SNOOZE_EN
      snz_nxt   = '0;
`endif
    end else begin
      case (state)
        DISARMED: state_nxt = ARMED;
        ARMED: if (match) begin
          state_nxt = RINGING;
          ring_nxt  = '0;
        end
        RINGING: begin
          if (stop) state_nxt = ARMED;
`ifdef ALARM_SNOOZE_EN
          else if (snooze) begin
            state_nxt = SNOOZING;
            snz_nxt   = SW'(SNOOZE_MINUTES);
          end
`endif
          else if (min_tick) begin
            if (ring_inc == RW'(RING_MINUTES)) begin
              state_nxt = ARMED;
              ring_nxt  = '0;
            end else
              ring_nxt = ring_inc;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZING: begin
          if (stop) state_nxt = ARMED;
          else if (min_tick) begin
            if (snz_cnt == SW'(1)) begin
              state_nxt = RINGING;
              ring_nxt  = '0;
            end
            snz_nxt = snz_cnt - SW'(1);
          end
        end
`endif
        default: state_nxt = DISARMED;
      endcase
    end
  end

  always_comb begin
    ringing  = (state == RINGING);
    armed    = (state != DISARMED);
`ifdef ALARM_SNOOZE_EN
    snoozing = (state == SNOOZING);
`else
    snoozing = 1'b0;
`endif
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_alarm_ctrl;

  localparam int HR_MOD = 24, MIN_MOD = 60, HR_W = 5, MIN_W = 6;
  localparam int RING_M = 2, SNOOZE_M = 5;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1;
  logic enable = 0, set_hr = 0, set_min = 0, set_dn = 0, arm = 0, stop = 0, snooze = 0, min_tick = 0;
  logic [HR_W-1:0]  cur_hr = '0;
  logic [MIN_W-1:0] cur_min = '0;
  logic [HR_W-1:0]  alarm_hr;
  logic [MIN_W-1:0] alarm_min;
  logic ringing, snoozing, armed;

  int checks = 0, failures = 0;

  alarm_ctrl #(.HR_MOD(HR_MOD), .MIN_MOD(MIN_MOD), .HR_W(HR_W), .MIN_W(MIN_W),
               .RING_MINUTES(RING_M), .SNOOZE_MINUTES(SNOOZE_M)) dut (
    .clock(clock), .reset(reset), .enable(enable), .set_hr(set_hr), .set_min(set_min),
    .set_dn(set_dn), .arm(arm), .stop(stop), .snooze(snooze), .min_tick(min_tick),
    .cur_hr(cur_hr), .cur_min(cur_min), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .ringing(ringing), .snoozing(snoozing), .armed(armed)
  );

  always #5 clock = ~clock;

  // Behavioural model: mode 0=off,1=waiting,2=ringing,3=snoozed; minutes remaining counted down.
  int m_hr = 0, m_min = 0, m_mode = 0, ring_left = 0, snz_left = 0;

  task automatic m_reset();
    m_hr = 0; m_min = 0; m_mode = 0; ring_left = 0; snz_left = 0;
  endtask

  task automatic m_step();
    bit hit;
    hit = min_tick && (int'(cur_hr) == m_hr) && (int'(cur_min) == m_min);
    if (enable && set_hr)  m_hr  = set_dn ? (m_hr + HR_MOD - 1) % HR_MOD : (m_hr + 1) % HR_MOD;
    if (enable && set_min) m_min = set_dn ? (m_min + MIN_MOD - 1) % MIN_MOD : (m_min + 1) % MIN_MOD;
    if (!arm) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (hit) begin m_mode = 2; ring_left = RING_M; end
    end else if (m_mode == 2) begin
      if (stop) m_mode = 1;
      else if (SNZ_EN && snooze) begin m_mode = 3; snz_left = SNOOZE_M; end
      else if (min_tick) begin
        ring_left--;
        if (ring_left == 0) m_mode = 1;
      end
    end else begin
      if (stop) m_mode = 1;
      else if (min_tick) begin
        snz_left--;
        if (snz_left == 0) begin m_mode = 2; ring_left = RING_M; end
      end
    end
  endtask

  always @(posedge clock) begin
    if (reset) m_reset();
    else m_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("model_alarm_hr", int'(alarm_hr), m_hr);
      chk("model_alarm_min", int'(alarm_min), m_min);
      chk("model_ringing", int'(ringing), int'(m_mode == 2));
      chk("model_snoozing", int'(snoozing), int'(m_mode == 3));
      chk("model_armed", int'(armed), int'(m_mode != 0));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    enable = 0; set_hr = 0; set_min = 0; set_dn = 0; stop = 0; snooze = 0; min_tick = 0;
  endtask

  task automatic tick(input int h, input int m);
    min_tick = 1; cur_hr = HR_W'(h); cur_min = MIN_W'(m);
    cyc();
    min_tick = 0;
  endtask

  initial begin
    cyc(); cyc();
    chk("reset_ringing", int'(ringing), 0);
    chk("reset_armed", int'(armed), 0);
    chk("reset_alarm_hr", int'(alarm_hr), 0);
    reset = 0;
    cyc();

    // Minute sweep with wrap; hour must stay put.
    enable = 1; set_min = 1;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      chk("min_sweep", int'(alarm_min), i % 60);
    end
    chk("hr_no_carry", int'(alarm_hr), 0);
    set_min = 0; set_hr = 1; set_dn = 1;
    cyc();
    chk("hr_down_wrap", int'(alarm_hr), 23);
    set_dn = 0;
    for (int i = 0; i < 8; i++) cyc();
    set_hr = 0; set_min = 1;
    for (int i = 0; i < 30; i++) cyc();
    quiet();
    chk("set_0730_hr", int'(alarm_hr), 7);
    chk("set_0730_min", int'(alarm_min), 30);

    arm = 1; cyc();
    chk("armed_after_arm", int'(armed), 1);
    tick(7, 29);
    chk("no_ring_0729", int'(ringing), 0);
    tick(7, 30);
    chk("ring_0730", int'(ringing), 1);

    tick(0, 0);
    chk("ring_after_1_tick", int'(ringing), 1);
    tick(0, 0);
    chk("ring_timeout", int'(ringing), 0);
    chk("armed_after_timeout", int'(armed), 1);

    tick(7, 30);
    chk("ring_again", int'(ringing), 1);
    stop = 1; snooze = 1; cyc(); quiet();
    chk("stop_wins_ring", int'(ringing), 0);
    chk("stop_wins_snz", int'(snoozing), 0);
    chk("stop_wins_armed", int'(armed), 1);
    arm = 0; cyc();
    chk("disarm", int'(armed), 0);

    arm = 1; cyc();
    tick(7, 30);
    chk("ring_pre_snooze", int'(ringing), 1);
    snooze = 1; cyc(); snooze = 0;
`ifdef ALARM_SNOOZE_EN
    chk("snoozing_on", int'(snoozing), 1);
    chk("snooze_silences", int'(ringing), 0);
    for (int i = 1; i <= 4; i++) begin
      tick(1, 1);
      chk("still_snoozing", int'(snoozing), 1);
    end
    tick(1, 1);
    chk("re_ring", int'(ringing), 1);
`else
    chk("snooze_ignored_ring", int'(ringing), 1);
    chk("snooze_ignored_snz", int'(snoozing), 0);
`endif

    // Async reset mid-ring, checked before any clock edge.
    #2 reset = 1; m_reset();
    #1;
    chk("async_rst_ringing", int'(ringing), 0);
    chk("async_rst_armed", int'(armed), 0);
    chk("async_rst_hr", int'(alarm_hr), 0);
    chk("async_rst_min", int'(alarm_min), 0);
    cyc(); reset = 0;
    cyc();

    // Randomized traffic; ticks often hit the current alarm setting.
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom_range(199, 0) == 0);
      enable   = ($urandom_range(9, 0) == 0);
      set_hr   = $urandom_range(1, 0);
      set_min  = $urandom_range(1, 0);
      set_dn   = $urandom_range(1, 0);
      arm      = ($urandom_range(39, 0) != 0);
      stop     = ($urandom_range(19, 0) == 0);
      snooze   = ($urandom_range(7, 0) == 0);
      min_tick = ($urandom_range(2, 0) == 0);
      if ($urandom_range(1, 0) == 1) begin
        cur_hr = HR_W'(m_hr); cur_min = MIN_W'(m_min);
      end else begin
        cur_hr = HR_W'($urandom_range(HR_MOD - 1, 0));
        cur_min = MIN_W'($urandom_range(MIN_MOD - 1, 0));
      end
      cyc();
    end
    reset = 0; quiet();
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Parametrised alarm unit: settable hour/minute alarm registers with up/down stepping and modulo wrap, plus an alarm state machine (disarmed/armed/ringing/snoozing).
- Compares the alarm setting against the running clock's hour and minute on each minute tick, drives a ring output with auto-timeout, and supports optional snooze.
- Sits beside the time-of-day counters; its outputs feed the display mux and the buzzer driver.

Parameters:
- HR_MOD, 24, hour counter modulus (wraps to 0 after HR_MOD-1)
- MIN_MOD, 60, minute counter modulus
- HR_W, 5, hour width; must satisfy 2^HR_W >= HR_MOD
- MIN_W, 6, minute width; must satisfy 2^MIN_W >= MIN_MOD
- RING_MINUTES, 1, min_tick pulses in RINGING before auto-stop (>=1)
- SNOOZE_MINUTES, 5, min_tick pulses spent in SNOOZING before re-ring (>=1)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  setting-step strobe, one step per cycle it is high
- set_hr  in  1  step hour register when enable=1
- set_min  in  1  step minute register when enable=1
- set_dn  in  1  step direction: 0=up, 1=down
- arm  in  1  level: 1=alarm armed, 0=disarmed
- stop  in  1  pulse: silence alarm
- snooze  in  1  pulse: snooze request (feature-dependent)
- min_tick  in  1  one-cycle pulse when current time enters a new minute
- cur_hr  in  HR_W  current hour, valid in the min_tick cycle
- cur_min  in  MIN_W  current minute, valid in the min_tick cycle
- alarm_hr  out  HR_W  alarm hour setting
- alarm_min  out  MIN_W  alarm minute setting
- ringing  out  1  high in RINGING
- snoozing  out  1  high in SNOOZING
- armed  out  1  high in ARMED, RINGING or SNOOZING

Behaviour:
- Reset (async): alarm_hr=0, alarm_min=0, state=DISARMED, ring/snooze counters=0. All outputs are 0.
- Setting:
  - With enable & set_x, register x steps by +1 (set_dn=0) or -1 (set_dn=1) on that edge.
  - Up from MOD-1 wraps to 0; down from 0 wraps to MOD-1.
  - set_hr and set_min both high: both step in the same cycle. Hour never changes on a minute wrap.
  - Setting is allowed in every state and never changes state.
- match = min_tick & (cur_hr==alarm_hr) & (cur_min==alarm_min), evaluated on register values before any same-cycle setting step.
- FSM states are DISARMED, ARMED, RINGING, SNOOZING. Priority per cycle: arm=0 > stop > snooze > counter/match events.
  - DISARMED: arm=1 -> ARMED on the next edge.
  - ARMED: match -> RINGING; ring counter loads 0.
  - RINGING:
    - stop -> ARMED.
    - snooze -> SNOOZING (feature only); snooze counter loads SNOOZE_MINUTES.
    - Each min_tick increments the ring counter. The tick that makes it reach RING_MINUTES -> ARMED.
    - match while RINGING is ignored.
  - SNOOZING:
    - stop -> ARMED.
    - Each min_tick decrements the snooze counter. The tick taking it from 1 to 0 -> RINGING, with the ring counter reloaded to 0.
  - Any state with arm=0 -> DISARMED next edge; counters clear.
- Outputs are registered and track state with 1-cycle latency from the causing input. ringing rises on the edge after the match cycle.
- Reset mid-ring or mid-snooze returns to DISARMED immediately; alarm settings clear.

Optional Feature:
- ALARM_SNOOZE_EN defined: snooze input honoured; SNOOZING state and snooze counter present.
- Undefined: snooze is ignored, SNOOZING is unreachable, and snoozing is tied to 0. RINGING ends only on stop, timeout or arm=0.

Decomposition:
- Shared package (clock_pkg): state encoding constants (DISARMED=2'd0, ARMED=2'd1, RINGING=2'd2, SNOOZING=2'd3) and the default moduli 24/60.
- One sub-module, mod_updown_counter (params MOD, W; ports clock, reset, step, dn, count). Instantiated twice, for hour and minute.

Test Plan:
- Reset, then set_min up 60 steps with enable=1 -> alarm_min goes 0..59 then wraps to 0; alarm_hr stays 0. set_hr down once from 0 -> alarm_hr=23.
- Alarm 07:30, arm=1, min_tick with cur 07:30 -> ringing=1 one cycle later. min_tick with cur 07:29 -> no ring.
- RINGING with RING_MINUTES=2 and no stop -> ringing falls on the edge after the 2nd min_tick; armed stays 1.
- RINGING, assert stop and snooze together -> ARMED (stop wins). Then arm=0 -> armed=0 next cycle.
- With ALARM_SNOOZE_EN and SNOOZE_MINUTES=5: snooze in RINGING -> snoozing=1; after the 5th min_tick, ringing=1 again. Without the macro, the same stimulus keeps ringing=1.
- Assert reset while RINGING -> ringing=0, alarm_hr=0, alarm_min=0 immediately, without waiting for a clock edge.
